// File: rtl/nios2_freertos_irq_ctrl.sv
// nios2_freertos_irq_ctrl
//
// Avalon-MM slave interrupt controller that sits between the system tick
// timer / peripheral irq outputs and the Nios II CPU. Each request line is
// either level or rising-edge sensitive. It is gated by a per-line enable
// mask and a global enable, and is OR-reduced into one registered CPU irq.
// The ACTIVE register gives the FreeRTOS ISR the highest-priority enabled
// pending line (line 0 highest) in a single read.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register word select (0..7)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   16-bit write data
//   readdata    registered read data (1-cycle read latency, no side effects)
//   irq_in      NUM_IRQ active-high requests, already in the clk domain
//   irq         registered interrupt request to the CPU
//
// Register map (word address):
//   0 PENDING   R: pending vector; W1C clears edge latches and FORCE bits
//   1 ENABLE    R/W per-line mask
//   2 EDGE_SEL  R/W, 1 = edge mode, 0 = level mode
//   3 ACTIVE    RO: bit15 valid, bits[3:0] lowest enabled pending index
//   4 FORCE     W1S software pending; R returns FORCE vector
//   5 CTRL      bit0 = GIE
//   6,7         read 0, writes ignored
module nios2_freertos_irq_ctrl #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [15:0] EDGE_RESET = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);

    // Register state
    logic [NUM_IRQ-1:0] enable_reg,     enable_next;
    logic [NUM_IRQ-1:0] edge_sel_reg,   edge_sel_next;
    logic [NUM_IRQ-1:0] edge_latch_reg, edge_latch_next;
    logic [NUM_IRQ-1:0] force_reg,      force_next;
    logic [NUM_IRQ-1:0] irq_in_d_reg;
    logic               gie_reg,        gie_next;
    logic [15:0]        readdata_reg,   readdata_next;
    logic               irq_reg,        irq_next;

    // Decoded write strobes
    logic wr;
    logic wr_pending;
    logic wr_enable;
    logic wr_edge_sel;
    logic wr_force;
    logic wr_ctrl;

    // Derived per-line vectors
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] req;

    // 16-bit zero-extended views for the read mux
    logic [15:0] pending_16;
    logic [15:0] enable_16;
    logic [15:0] edge_sel_16;
    logic [15:0] force_16;

    // Priority encoder result
    logic       active_valid;
    logic [3:0] active_idx;

    // Upper writedata bits are deliberately ignored when NUM_IRQ < 16
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr          = chipselect & ~write_n;
    assign wr_pending  = wr && (address == 3'd0);
    assign wr_enable   = wr && (address == 3'd1);
    assign wr_edge_sel = wr && (address == 3'd2);
    assign wr_force    = wr && (address == 3'd4);
    assign wr_ctrl     = wr && (address == 3'd5);

    assign rise = irq_in & ~irq_in_d_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            assign enable_next[gi]   = wr_enable   ? writedata[gi] : enable_reg[gi];
            assign edge_sel_next[gi] = wr_edge_sel ? writedata[gi] : edge_sel_reg[gi];

            // Leaving edge mode discards any latched edge. Otherwise a new
            // rising edge beats a simultaneous W1C so no event is lost.
            assign edge_latch_next[gi] =
                (edge_sel_reg[gi] & ~edge_sel_next[gi]) ? 1'b0 :
                (edge_sel_reg[gi] & rise[gi])           ? 1'b1 :
                (wr_pending & writedata[gi])            ? 1'b0 :
                                                          edge_latch_reg[gi];

            // Set and clear live at different addresses, so they never collide
            assign force_next[gi] =
                (wr_force   & writedata[gi]) ? 1'b1 :
                (wr_pending & writedata[gi]) ? 1'b0 :
                                               force_reg[gi];

            // A level line follows its input directly; W1C cannot touch it
            assign pending[gi] = force_reg[gi] |
                                 (edge_sel_reg[gi] ? edge_latch_reg[gi] : irq_in[gi]);
        end

        for (gi = 0; gi < 16; gi++) begin : g_pad
            if (gi < NUM_IRQ) begin : g_used
                assign pending_16[gi]  = pending[gi];
                assign enable_16[gi]   = enable_reg[gi];
                assign edge_sel_16[gi] = edge_sel_reg[gi];
                assign force_16[gi]    = force_reg[gi];
            end else begin : g_zero
                assign pending_16[gi]  = 1'b0;
                assign enable_16[gi]   = 1'b0;
                assign edge_sel_16[gi] = 1'b0;
                assign force_16[gi]    = 1'b0;
            end
        end
    endgenerate

    assign req      = pending & enable_reg;
    assign gie_next = wr_ctrl ? writedata[0] : gie_reg;
    assign irq_next = gie_reg & (|req);

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        active_valid = 1'b0;
        active_idx   = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                active_valid = 1'b1;
                active_idx   = i[3:0];
            end
        end
    end

    // ACTIVE is computed from the same state as PENDING, so one captured
    // readdata word is always self-consistent.
    always_comb begin
        readdata_next = 16'h0000;
        case (address)
            3'd0:    readdata_next = pending_16;
            3'd1:    readdata_next = enable_16;
            3'd2:    readdata_next = edge_sel_16;
            3'd3:    readdata_next = active_valid ? {1'b1, 11'b0, active_idx} : 16'h0000;
            3'd4:    readdata_next = force_16;
            3'd5:    readdata_next = {15'b0, gie_reg};
            default: readdata_next = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_reg     <= '0;
            edge_sel_reg   <= EDGE_RESET[NUM_IRQ-1:0];
            edge_latch_reg <= '0;
            force_reg      <= '0;
            irq_in_d_reg   <= '0;
            gie_reg        <= 1'b0;
            readdata_reg   <= 16'h0000;
            irq_reg        <= 1'b0;
        end else begin
            enable_reg     <= enable_next;
            edge_sel_reg   <= edge_sel_next;
            edge_latch_reg <= edge_latch_next;
            force_reg      <= force_next;
            irq_in_d_reg   <= irq_in;
            gie_reg        <= gie_next;
            readdata_reg   <= readdata_next;
            irq_reg        <= irq_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = irq_reg;

endmodule
